// File: rtl/seq_restoring_div_16x8.sv
// -----------------------------------------------------------------------------
// seq_restoring_div_16x8
//
// Sequential restoring divider for the DCT datapath. It is the inverse-path
// companion to the approximate Vedic multiplier and is used for coefficient
// normalisation and quantisation. Arithmetic is exact.
//
// The divider resolves one quotient bit per clock. Each trial subtraction is a
// ripple-borrow chain of full-adder cells that compute a + ~b + 1. A nonzero
// divide takes DW RUN cycles and is followed by one DONE cycle. A divide by
// zero skips RUN and reaches DONE on the accepting edge.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset; aborts a run without a done
//   start        request; accepted on a clk edge while not in RUN
//   dividend     DW-bit unsigned dividend, captured on the accepting edge
//   divisor      VW-bit unsigned divisor, captured on the accepting edge
//   busy         high while the iteration is running
//   done         one-cycle pulse; results are valid in that cycle
//   quotient     DW-bit result, held until the next result or reset
//   remainder    VW-bit result, held until the next result or reset
//   div_by_zero  set together with done when the captured divisor was zero
// -----------------------------------------------------------------------------
module seq_restoring_div_16x8 #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            accept;
  logic            divisor_zero;
  logic            last_iter;

  logic [DW-1:0]   q_sr;        // dividend shifts out, quotient bits shift in
  logic [DW-1:0]   q_next;
  logic [VW-1:0]   r_sr;        // partial remainder, always < divisor
  logic [VW-1:0]   r_next;
  logic [VW-1:0]   divisor_q;
  logic [CW-1:0]   count;

  // The shifted remainder can reach 2*divisor-1, so the trial is one bit wider
  // than the stored remainder.
  logic [VW:0]     shifted;
  logic [VW:0]     sub_b;
  logic [VW:0]     trial;
  logic [VW+1:0]   carry;
  logic            no_borrow;
  logic            trial_msb_unused;

  // The team's full-adder cell. It returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
    return {(a & b) | (cin & (a ^ b)), a ^ b ^ cin};
  endfunction

  assign divisor_zero = (divisor == '0);
  assign last_iter    = (count == '0);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples the values from before the edge, whatever the process order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and status outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block is given a default first. An output left
  // unassigned on some path would infer a latch.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) begin
          accept     = 1'b1;
          state_next = divisor_zero ? DONE : RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Trial subtraction: shifted - {0, divisor} as shifted + ~{0, divisor} + 1.
  // A carry out of the top cell means no borrow, so the trial result is >= 0.
  // ---------------------------------------------------------------------------
  assign shifted  = {r_sr, q_sr[DW-1]};
  assign sub_b    = ~{1'b0, divisor_q};
  assign carry[0] = 1'b1;

  for (genvar i = 0; i <= VW; i++) begin : g_borrow_chain
    assign {carry[i+1], trial[i]} = full_add(shifted[i], sub_b[i], carry[i]);
  end

  assign no_borrow = carry[VW+1];

  // A kept trial is below the divisor, so its top bit is always zero.
  assign trial_msb_unused = trial[VW];

  // A restore keeps the shifted value. It is below the divisor, so its top
  // bit is zero as well.
  assign r_next = no_borrow ? trial[VW-1:0] : shifted[VW-1:0];
  assign q_next = {q_sr[DW-2:0], no_borrow};

  // ---------------------------------------------------------------------------
  // Datapath and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      q_sr        <= '0;
      r_sr        <= '0;
      divisor_q   <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      if (divisor_zero) begin
        // Saturated quotient with a flag. No iteration is needed.
        quotient    <= '1;
        remainder   <= '0;
        div_by_zero <= 1'b1;
      end else begin
        divisor_q   <= divisor;
        q_sr        <= dividend;
        r_sr        <= '0;
        count       <= CW'(DW - 1);
        div_by_zero <= 1'b0;
      end
    end else if (state == RUN) begin
      q_sr  <= q_next;
      r_sr  <= r_next;
      count <= count - 1'b1;
      // The published result is updated only on the final iteration. It
      // keeps the previous answer for the whole run.
      if (last_iter) begin
        quotient  <= q_next;
        remainder <= r_next;
      end
    end
  end

endmodule

// File: tb/tb_seq_restoring_div_16x8.sv
// -----------------------------------------------------------------------------
// tb_seq_restoring_div_16x8
//
// Directed and swept stimulus for seq_restoring_div_16x8.
//
// A cycle-level reference model predicts busy, done and the held results from
// plain division and modulo. One compare process checks the DUT against the
// model every cycle. Directed cases also check literal results and latencies.
// -----------------------------------------------------------------------------
module tb_seq_restoring_div_16x8;

  localparam int DW = 16;
  localparam int VW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  seq_restoring_div_16x8 #(.DW(DW), .VW(VW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. It is evaluated on every rising edge. It tracks when the
  // pending answer appears, and it does not model the iteration itself.
  // ---------------------------------------------------------------------------
  bit            model_live = 1'b0;
  int            cyc        = 0;
  bit            in_flight  = 1'b0;
  int            done_at    = 0;
  int            done_cycle = -1;
  bit            blocked;
  logic [DW-1:0] pend_q, held_q;
  logic [VW-1:0] pend_r, held_r;
  logic          held_dbz;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      model_live = 1'b1;
      in_flight  = 1'b0;
      done_cycle = -1;
      held_q     = '0;
      held_r     = '0;
      held_dbz   = 1'b0;
    end else if (model_live) begin
      blocked = in_flight;
      if (in_flight && cyc == done_at) begin
        held_q     = pend_q;
        held_r     = pend_r;
        in_flight  = 1'b0;
        done_cycle = cyc;
      end
      if (!blocked && start) begin
        if (divisor == '0) begin
          held_q     = '1;
          held_r     = '0;
          held_dbz   = 1'b1;
          done_cycle = cyc;
        end else begin
          pend_q    = dividend / divisor;
          pend_r    = VW'(dividend % divisor);
          held_dbz  = 1'b0;
          in_flight = 1'b1;
          done_at   = cyc + DW;
        end
      end
    end
  end

  // A single compare process that runs away from the active edge.
  always @(negedge clk) begin
    if (model_live) begin
      check($sformatf("cyc%0d_busy", cyc), busy, in_flight);
      check($sformatf("cyc%0d_done", cyc), done, (done_cycle == cyc));
      check($sformatf("cyc%0d_quotient", cyc), quotient, held_q);
      check($sformatf("cyc%0d_remainder", cyc), remainder, held_r);
      check($sformatf("cyc%0d_div_by_zero", cyc), div_by_zero, held_dbz);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. Each one is entered and left at a falling edge.
  // ---------------------------------------------------------------------------
  task automatic issue(input logic [DW-1:0] dd, input logic [VW-1:0] dv);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = DW'($urandom);
    divisor  = VW'($urandom);
  endtask

  // The first sample is the cycle after the accepting edge. edges counts the
  // rising edges after the accepting edge up to the done cycle.
  task automatic await_done(input bit poke, output int edges, output int busy_cycles);
    edges       = -1;
    busy_cycles = 0;
    for (int k = 0; k < 40; k++) begin
      if (done === 1'b1) begin
        edges = k;
        break;
      end
      if (busy === 1'b1) busy_cycles++;
      if (poke && (k == 2 || k == 9)) begin
        start    = 1'b1;
        dividend = 16'd9;
        divisor  = 8'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("done_seen", done, 1'b1);
  endtask

  task automatic expect_result(input string name, input logic [DW-1:0] eq,
                               input logic [VW-1:0] er, input logic edbz);
    check({name, "_quotient"}, quotient, eq);
    check({name, "_remainder"}, remainder, er);
    check({name, "_div_by_zero"}, div_by_zero, edbz);
  endtask

  task automatic run_op(input string name, input logic [DW-1:0] dd, input logic [VW-1:0] dv,
                        input logic [DW-1:0] eq, input logic [VW-1:0] er, input logic edbz,
                        input int eedges);
    int e, b;
    issue(dd, dv);
    await_done(1'b0, e, b);
    expect_result(name, eq, er, edbz);
    check({name, "_edges"}, e, eedges);
  endtask

  task automatic count_stray_done(input string name);
    int extra;
    extra = 0;
    repeat (DW + 4) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    check(name, extra, 0);
  endtask

  typedef struct {
    logic [DW-1:0] dd;
    logic [VW-1:0] dv;
    logic [DW-1:0] q;
    logic [VW-1:0] r;
  } vec_t;

  vec_t bounds[6] = '{
    '{16'd0,     8'd5,   16'd0,     8'd0},
    '{16'd200,   8'd1,   16'd200,   8'd0},
    '{16'd65535, 8'd1,   16'd65535, 8'd0},
    '{16'd254,   8'd255, 16'd0,     8'd254},
    '{16'd255,   8'd255, 16'd1,     8'd0},
    '{16'd65534, 8'd255, 16'd256,   8'd254}
  };

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, b;
    logic [DW-1:0] dd;
    logic [VW-1:0] dv;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    expect_result("reset", 16'd0, 8'd0, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // 1000 / 7: 16 busy cycles, done on the 16th edge after acceptance.
    issue(16'd1000, 8'd7);
    await_done(1'b0, e, b);
    expect_result("div_1000_7", 16'd142, 8'd6, 1'b0);
    check("div_1000_7_edges", e, 16);
    check("div_1000_7_busy_cycles", b, 16);
    @(negedge clk);

    run_op("div_65535_255", 16'd65535, 8'd255, 16'd257, 8'd0, 1'b0, 16);
    run_op("div_5_9",       16'd5,     8'd9,   16'd0,   8'd5, 1'b0, 16);
    run_op("div_1234_0",    16'd1234,  8'd0,   16'hFFFF, 8'd0, 1'b1, 0);
    run_op("div_100_10",    16'd100,   8'd10,  16'd10,  8'd0, 1'b0, 16);
    @(negedge clk);

    // Start pulses during RUN must be ignored.
    issue(16'd40000, 8'd3);
    await_done(1'b1, e, b);
    expect_result("div_40000_3", 16'd13333, 8'd1, 1'b0);
    check("div_40000_3_edges", e, 16);
    count_stray_done("div_40000_3_single_done");

    // Back-to-back: the next start is applied during the done cycle.
    issue(16'd1000, 8'd7);
    await_done(1'b0, e, b);
    expect_result("b2b_first", 16'd142, 8'd6, 1'b0);
    issue(16'd500, 8'd13);
    await_done(1'b0, e, b);
    expect_result("b2b_500_13", 16'd38, 8'd6, 1'b0);
    check("b2b_500_13_edges", e, 16);
    @(negedge clk);

    // Reset in the middle of a run clears everything and produces no done.
    issue(16'd60000, 8'd250);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    expect_result("abort", 16'd0, 8'd0, 1'b0);
    rst = 1'b0;
    count_stray_done("abort_no_done");
    run_op("div_60000_250", 16'd60000, 8'd250, 16'd240, 8'd0, 1'b0, 16);

    foreach (bounds[i]) begin
      run_op($sformatf("bound%0d", i), bounds[i].dd, bounds[i].dv,
             bounds[i].q, bounds[i].r, 1'b0, 16);
    end

    // Back-to-back operand sweep, with a zero divisor every so often.
    for (int i = 0; i < 2000; i++) begin
      dd = DW'($urandom);
      dv = (i % 97 == 0) ? VW'(0) : VW'($urandom);
      issue(dd, dv);
      await_done(1'b0, e, b);
      if (dv == '0) begin
        check($sformatf("sweep%0d_dbz", i), div_by_zero, 1'b1);
        check($sformatf("sweep%0d_sat", i), quotient, 16'hFFFF);
      end else begin
        check($sformatf("sweep%0d_dbz", i), div_by_zero, 1'b0);
        check($sformatf("sweep%0d_identity", i),
              int'(quotient) * int'(dv) + int'(remainder), int'(dd));
        check($sformatf("sweep%0d_rem_lt_div", i), (remainder < dv), 1'b1);
      end
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
